// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - time-multiplexed hex scanner for an N-digit common-anode 7-segment display
//   clk, reset_n             : clock, asynchronous active-low reset
//   load, value, dp_mask     : strobe that captures a new value and decimal points (double-buffered)
//   digit, dp_n, anode       : registered nibble, active-low decimal point, active-low digit enables
//   frame_tick, pending      : commit pulse, uncommitted-load flag
//   Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit)
module hex_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [3:0]              digit,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_tick,
    output logic                    pending
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pending_q, pending_d;
    logic [3:0]              digit_q, digit_d;
    logic                    dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_tick_q, frame_tick_d;

    logic slot_end;
    logic commit;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_above;

    // Walk from the most significant digit down; a digit is blank while
    // everything at or above it is a zero nibble with no decimal point.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp_q[4*i +: 4] == 4'h0) && !disp_dp_q[i];
            blank[i]   = zero_above && (i != 0);
        end
    end
`endif

    always_comb begin
        slot_end = (presc_q == PRESC_LAST);
        commit   = slot_end && (idx_q == IDX_LAST);

        presc_d = slot_end ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        disp_d     = disp_q;
        disp_dp_d  = disp_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pending_d  = pending_q;

        if (commit) begin
            // A load landing on the commit edge bypasses the pending buffer.
            if (load) begin
                disp_d    = value;
                disp_dp_d = dp_mask;
            end else if (pending_q) begin
                disp_d    = pend_val_q;
                disp_dp_d = pend_dp_q;
            end
            pending_d = 1'b0;
        end else if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_mask;
            pending_d  = 1'b1;
        end

        frame_tick_d = commit;

        // Outputs follow the current slot index one edge later.
        digit_d = disp_q[{idx_q, 2'b00} +: 4];
        anode_d = ~(NUM_DIGITS'(1) << idx_q);
        dp_n_d  = ~disp_dp_q[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
        if (blank[idx_q]) begin
            anode_d = '1;
            dp_n_d  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            disp_dp_q    <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pending_q    <= 1'b0;
            digit_q      <= 4'h0;
            dp_n_q       <= 1'b1;
            anode_q      <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            disp_dp_q    <= disp_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pending_q    <= pending_d;
            digit_q      <= digit_d;
            dp_n_q       <= dp_n_d;
            anode_q      <= anode_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign digit      = digit_q;
    assign dp_n       = dp_n_q;
    assign anode      = anode_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - self-checking bench for hex_display_scanner
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  digit;
    logic        dp_n;
    logic [3:0]  anode;
    logic        frame_tick;
    logic        pending;

    logic        rst1_n;
    logic        load1;
    logic [15:0] value1;
    logic [3:0]  dp_mask1;
    logic [3:0]  digit1;
    logic        dp1_n;
    logic [3:0]  anode1;
    logic        ft1;
    logic        pend1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] anode;
        logic [3:0] digit;
        logic       dp_n;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .value(value), .dp_mask(dp_mask),
        .digit(digit), .dp_n(dp_n), .anode(anode), .frame_tick(frame_tick), .pending(pending)
    );

    hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(1)) dut_fast (
        .clk(clk), .reset_n(rst1_n), .load(load1), .value(value1), .dp_mask(dp_mask1),
        .digit(digit1), .dp_n(dp1_n), .anode(anode1), .frame_tick(ft1), .pending(pend1)
    );

    // Expected outputs for one full frame (4 slots x 4 cycles), slot 0 first.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp);
        exp_t        e;
        logic [15:0] vv;
        logic [3:0]  dd;
        logic        blank;
        for (int s = 0; s < 4; s++) begin
            vv    = v >> (4 * s);
            dd    = dp >> s;
            blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank = (s != 0) && (vv == 16'h0) && (dd == 4'h0);
`endif
            e.anode = blank ? 4'b1111 : ~(4'b0001 << s);
            e.digit = vv[3:0];
            e.dp_n  = blank ? 1'b1 : ~dd[0];
            repeat (4) exp_q.push_back(e);
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; load = 1'b0; value = '0; dp_mask = '0;
        rst1_n = 1'b0; load1 = 1'b0; value1 = '0; dp_mask1 = '0;
        repeat (3) @(negedge clk);
        checks++; if (anode !== 4'b1111) begin errors++; $display("FAIL reset_anode got %b want 1111", anode); end
        checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp_n got %b want 1", dp_n); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got %b want 0", frame_tick); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
        checks++; if (digit !== 4'h0) begin errors++; $display("FAIL reset_digit got %h want 0", digit); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (anode !== 4'b1110) begin errors++; $display("FAIL first_edge_anode got %b want 1110", anode); end
        checks++; if (digit !== 4'h0) begin errors++; $display("FAIL first_edge_digit got %h want 0", digit); end
    endtask

    task automatic test_scan;
        exp_t e;
        bit   ok;
        value = 16'h1234; dp_mask = 4'b0100; load = 1'b1;
        @(negedge clk);
        load = 1'b0; value = 16'hFFFF; dp_mask = 4'b1111;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL scan_pending got %b want 1", pending); end
        wait_tick(ok);
        checks++; if (!ok) begin errors++; $display("FAIL scan_tick_timeout got none want frame_tick"); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL scan_commit_pending got %b want 0", pending); end
        push_frame(16'h1234, 4'b0100);
        push_frame(16'h1234, 4'b0100);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({anode, digit, dp_n} !== e) begin
                errors++;
                $display("FAIL scan_slot i=%0d got %b/%h/%b want %b/%h/%b", i, anode, digit, dp_n, e.anode, e.digit, e.dp_n);
            end
            checks++;
            if (frame_tick !== (i % 16 == 15)) begin
                errors++; $display("FAIL scan_frame_tick i=%0d got %b want %b", i, frame_tick, (i % 16 == 15));
            end
        end
    endtask

    task automatic test_no_tear;
        exp_t e;
        push_frame(16'h1234, 4'b0100);
        push_frame(16'hABCD, 4'b0000);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({anode, digit, dp_n} !== e) begin
                errors++;
                $display("FAIL no_tear_slot i=%0d got %b/%h/%b want %b/%h/%b", i, anode, digit, dp_n, e.anode, e.digit, e.dp_n);
            end
            checks++;
            if (frame_tick !== (i % 16 == 15)) begin
                errors++; $display("FAIL no_tear_frame_tick i=%0d got %b want %b", i, frame_tick, (i % 16 == 15));
            end
            if (i == 4) begin
                value = 16'hABCD; dp_mask = 4'b0000; load = 1'b1;
            end else if (i == 5) begin
                load = 1'b0; value = 16'h0000;
                checks++; if (pending !== 1'b1) begin errors++; $display("FAIL no_tear_pending got %b want 1", pending); end
            end else if (i == 15) begin
                checks++; if (pending !== 1'b0) begin errors++; $display("FAIL no_tear_commit_pending got %b want 0", pending); end
            end
        end
    endtask

    task automatic test_simultaneous;
        exp_t e;
        push_frame(16'hABCD, 4'b0000);
        push_frame(16'h5A5A, 4'b0000);
        push_frame(16'h2222, 4'b0000);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({anode, digit, dp_n} !== e) begin
                errors++;
                $display("FAIL simul_slot i=%0d got %b/%h/%b want %b/%h/%b", i, anode, digit, dp_n, e.anode, e.digit, e.dp_n);
            end
            checks++;
            if (frame_tick !== (i % 16 == 15)) begin
                errors++; $display("FAIL simul_frame_tick i=%0d got %b want %b", i, frame_tick, (i % 16 == 15));
            end
            if (i <= 16) begin
                checks++; if (pending !== 1'b0) begin errors++; $display("FAIL bypass_pending i=%0d got %b want 0", i, pending); end
            end
            if (i == 14) begin
                value = 16'h5A5A; load = 1'b1;
            end else if (i == 15) begin
                load = 1'b0;
            end else if (i == 18) begin
                value = 16'h1111; load = 1'b1;
            end else if (i == 19) begin
                load = 1'b0;
                checks++; if (pending !== 1'b1) begin errors++; $display("FAIL double_load_pending got %b want 1", pending); end
            end else if (i == 22) begin
                value = 16'h2222; load = 1'b1;
            end else if (i == 23) begin
                load = 1'b0; value = 16'h9999;
            end else if (i == 28) begin
                checks++; if (pending !== 1'b1) begin errors++; $display("FAIL double_load_pending2 got %b want 1", pending); end
            end else if (i == 31) begin
                checks++; if (pending !== 1'b0) begin errors++; $display("FAIL double_load_commit got %b want 0", pending); end
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        bit   ok;
        push_frame(16'h2222, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({anode, digit, dp_n} !== e) begin
                errors++;
                $display("FAIL midrst_slot i=%0d got %b/%h/%b want %b/%h/%b", i, anode, digit, dp_n, e.anode, e.digit, e.dp_n);
            end
            if (i == 0) begin
                value = 16'hFFFF; dp_mask = 4'b1111; load = 1'b1;
            end else if (i == 1) begin
                load = 1'b0;
            end
        end
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL midrst_pending_before got %b want 1", pending); end
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        checks++; if (anode !== 4'b1111) begin errors++; $display("FAIL midrst_anode got %b want 1111", anode); end
        checks++; if (digit !== 4'h0) begin errors++; $display("FAIL midrst_digit got %h want 0", digit); end
        checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL midrst_dp_n got %b want 1", dp_n); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL midrst_frame_tick got %b want 0", frame_tick); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL midrst_pending got %b want 0", pending); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (anode !== 4'b1110) begin errors++; $display("FAIL midrst_first_anode got %b want 1110", anode); end
        wait_tick(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_tick_timeout got none want frame_tick"); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL midrst_dropped_pending got %b want 0", pending); end
        push_frame(16'h0000, 4'b0000);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({anode, digit, dp_n} !== e) begin
                errors++;
                $display("FAIL midrst_frame i=%0d got %b/%h/%b want %b/%h/%b", i, anode, digit, dp_n, e.anode, e.digit, e.dp_n);
            end
        end
    endtask

    task automatic test_leading_zero;
        exp_t e;
        push_frame(16'h0000, 4'b0000);
        push_frame(16'h0042, 4'b0000);
        push_frame(16'h0000, 4'b0000);
        push_frame(16'h0000, 4'b0100);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({anode, digit, dp_n} !== e) begin
                errors++;
                $display("FAIL lzb_slot i=%0d got %b/%h/%b want %b/%h/%b", i, anode, digit, dp_n, e.anode, e.digit, e.dp_n);
            end
            if (i == 2) begin
                value = 16'h0042; dp_mask = 4'b0000; load = 1'b1;
            end else if (i == 18) begin
                value = 16'h0000; dp_mask = 4'b0000; load = 1'b1;
            end else if (i == 34) begin
                value = 16'h0000; dp_mask = 4'b0100; load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
    endtask

    task automatic test_fast_refresh;
        logic [3:0] want;
        checks++; if (anode1 !== 4'b1111) begin errors++; $display("FAIL fast_reset_anode got %b want 1111", anode1); end
        rst1_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            want = ~(4'b0001 << ((k - 1) % 4));
            checks++;
            if (anode1 !== want) begin errors++; $display("FAIL fast_anode k=%0d got %b want %b", k, anode1, want); end
            checks++;
            if (ft1 !== (k % 4 == 0)) begin errors++; $display("FAIL fast_frame_tick k=%0d got %b want %b", k, ft1, (k % 4 == 0)); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_no_tear();
        test_simultaneous();
        test_reset_mid();
        test_leading_zero();
        test_fast_refresh();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
